// File: rtl/spi_cmd_deserializer_fifo.sv
// SPI command frame receiver feeding a first-word-fall-through frame FIFO.
// Define SPI_PARITY_EN to append and check an even-parity bit per frame.
module spi_cmd_deserializer_fifo #(
  parameter int ADDRW       = 8,
  parameter int OPCODEW     = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int SHIFT_W    = OPCODEW + 2 * ADDRW,
  localparam int CNTW       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_clk,
  input  logic               mosi,
  input  logic               cs_n,
  input  logic               ready_in,
  output logic [OPCODEW-1:0] opcode,
  output logic [ADDRW-1:0]   key_addr,
  output logic [ADDRW-1:0]   text_addr,
  output logic               valid_out,
  output logic [CNTW-1:0]    count,
  output logic               frame_err,
  output logic               overrun,
  output logic               parity_err
);

`ifdef SPI_PARITY_EN
  localparam int FRAME_W = SHIFT_W + 1;
`else
  localparam int FRAME_W = SHIFT_W;
`endif
  localparam int BCW  = $clog2(FRAME_W + 1);
  localparam int PTRW = $clog2(DEPTH);
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(FRAME_W - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_prev;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sclk_rise;

  state_t             state;
  state_t             state_nx;
  logic [BCW-1:0]     bit_cnt;
  logic [BCW-1:0]     bit_cnt_nx;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] shreg_nx;
  logic [FRAME_W-1:0] word_in;
  logic [SHIFT_W-1:0] data;
  logic               done;
  logic               ferr_nx;
  logic               par_ok;

  logic [SHIFT_W-1:0] mem [DEPTH];
  logic [SHIFT_W-1:0] head;
  logic [PTRW-1:0]    wptr;
  logic [PTRW-1:0]    rptr;
  logic               pop;
  logic               good;
  logic               push;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  // Bring the SPI pins into clk and keep one extra flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_prev <= sclk_s;
    end
  end

  assign word_in = {shreg[FRAME_W-2:0], mosi_s};
  assign data    = word_in[FRAME_W-1 -: SHIFT_W];

`ifdef SPI_PARITY_EN
  assign par_ok = ((^data) == word_in[0]);
`else
  assign par_ok = 1'b1;
`endif

  // Receiver next state: shift on sclk rise, close frame on last bit
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    done       = 1'b0;
    ferr_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cs_s) state_nx = SHIFT;
      end
      SHIFT: begin
        if (cs_s) begin
          state_nx   = IDLE;
          bit_cnt_nx = '0;
          ferr_nx    = (bit_cnt != '0);
        end else if (sclk_rise) begin
          shreg_nx = word_in;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nx = '0;
            done       = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
    end
  end

  assign valid_out = (count != '0);
  assign pop       = valid_out & ready_in;
  assign good      = done & par_ok;
  assign push      = good & ((count != FULL_CNT) | pop);
  assign head      = mem[rptr];
  assign opcode    = head[SHIFT_W-1 -: OPCODEW];
  assign key_addr  = head[SHIFT_W-OPCODEW-1 -: ADDRW];
  assign text_addr = head[ADDRW-1:0];

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Registered one-cycle error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_nx;
      overrun   <= good & ~push;
    end
  end

`ifdef SPI_PARITY_EN
  // Parity mismatch pulse; such frames never reach the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= done & ~par_ok;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
